mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Sequencer for the add_shift multiplier in the RISC-V core datapath. Accepts an M-extension multiply from decode, converts operands to unsigned magnitudes, drives the multiplier load/valid handshake, and sign-corrects the 64-bit product. Selects the low or high word and arbitrates the single regfile write port against ALU writeback. Stalls issue while a multiply is in flight.

## Interface
- XLEN, 32: operand and regfile data width.
- TIMEOUT, 64: max cycles in WAIT without mul_valid before abort.

- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents a multiply (opcode 0110011, funct7 0000001)
- issue_ready  out  1  controller can accept; high only in IDLE
- issue_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- issue_rd  in  5  destination register
- issue_rs1_data  in  XLEN  rs1 operand
- issue_rs2_data  in  XLEN  rs2 operand
- mul_ld  out  1  one-cycle start pulse to multiplier
- mul_a  out  XLEN  magnitude of rs2 operand, stable LOAD..WAIT
- mul_b  out  XLEN  magnitude of rs1 operand, stable LOAD..WAIT
- mul_out  in  2*XLEN  unsigned product
- mul_valid  in  1  product valid
- alu_wb_en  in  1  ALU writeback request
- alu_wb_rd  in  5  ALU destination
- alu_wb_data  in  XLEN  ALU result
- rf_write_en  out  1  regfile write enable
- rf_write_reg  out  5  regfile write address
- rf_write_data  out  XLEN  regfile write data
- busy  out  1  state != IDLE; used as pipeline stall
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, LOAD, WAIT, WB.
- IDLE: issue_ready=1. On issue_valid, latch funct3, rd, magnitudes, neg flag → LOAD.
- Signedness: MULH treats both operands as signed. MULHSU treats rs1 signed and rs2 unsigned. MUL and MULHU treat both as unsigned. A signed operand with MSB set is two's-complemented; 0x80000000 yields magnitude 0x80000000. neg = sign_rs1 ^ sign_rs2.
- LOAD: mul_ld=1 for exactly this cycle → WAIT.
- WAIT: on mul_valid, register result = neg ? -(mul_out) : mul_out (2*XLEN two's complement) → WB. The timeout counter increments each WAIT cycle. When it reaches TIMEOUT without mul_valid: set err, go to IDLE, perform no write.
- WB: MUL writes result[XLEN-1:0]; MULH, MULHSU and MULHU write result[2*XLEN-1:XLEN].
- Write port is combinational. ALU always has priority: if alu_wb_en, rf_write_* = alu_wb_*, and the multiply result waits in WB. Otherwise in WB with rd≠0: rf_write_en=1, rf_write_reg=rd, rf_write_data=selected word → IDLE.
- rd=0: WB writes nothing and goes to IDLE in one cycle.
- ALU writes pass through in every state.
- mul_valid outside WAIT is ignored.

## Timing
- Reset values: state IDLE, issue_ready=1, busy=0, err=0, mul_ld=0, mul_a=mul_b=0, result=0, counter=0. rf_write_en follows alu_wb_en.
- Accept at cycle 0, mul_ld at cycle 1, WAIT from cycle 2.
- mul_valid sampled at cycle N → write at cycle N+1 if the port is free.
- After WB completes, IDLE is entered the next cycle; back-to-back issue is therefore possible one cycle after the write.
- rst in any state aborts the operation: the pending result is dropped and no write occurs. The multiplier shares rst.
- err clears only on rst.

## Configuration
- MUL_ZERO_BYPASS_EN defined: in IDLE, if either operand is zero, go directly to WB with result=0. mul_ld is never pulsed, and the write occurs one cycle after accept.
- Undefined: all multiplies go through LOAD/WAIT.

## Test plan
- MUL rs1=7, rs2=6, rd=5, multiplier valid 33 cycles after ld → mul_ld high only at cycle 1; x5=42 written the cycle after mul_valid; busy low the following cycle.
- rs1=0xFFFFFFFF, rs2=2 → MULH writes 0xFFFFFFFF; MULHU writes 0x00000001; MULHSU writes 0xFFFFFFFF; MUL writes 0xFFFFFFFE.
- MULH rs1=0x80000000, rs2=0x80000000 → mul_a=mul_b=0x80000000, writes 0x40000000.
- WB collision: alu_wb_en=1 (rd=3, data=0x11) for 3 cycles during WB → three ALU writes pass through, the multiply write lands on the 4th cycle, and issue_ready stays 0 until then.
- rd=0 multiply → rf_write_en never asserted by the controller; IDLE one cycle after WB. Separately, mul_valid held low → err=1 after 64 WAIT cycles, no write, issue_ready=1.
- rst asserted in WAIT → next cycle all outputs at reset values, and a late mul_valid causes no write. With MUL_ZERO_BYPASS_EN, 0×5 to rd=4 → no mul_ld, x4=0 written at cycle 1.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencer around the add_shift multiplier.
// It accepts an M-extension multiply and drives the multiplier with unsigned
// operand magnitudes. It sign-corrects the 64-bit product and writes the
// selected word through the single regfile write port. ALU writeback always
// has priority on that port.
//
// Optional build macro: MUL_ZERO_BYPASS_EN
//   When this macro is defined, a multiply with a zero operand skips the
//   multiplier and goes straight to writeback with a result of 0.
//
// state | meaning
// IDLE  | ready for a new multiply; issue_ready high
// LOAD  | one-cycle mul_ld pulse with operand magnitudes
// WAIT  | waiting for mul_valid; timeout counter running
// WB    | result held until the write port is free (or rd=0)
module mul_seq_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_funct3,
    input  logic [4:0]        issue_rd,
    input  logic [XLEN-1:0]   issue_rs1_data,
    input  logic [XLEN-1:0]   issue_rs2_data,
    output logic              mul_ld,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic [2*XLEN-1:0] mul_out,
    input  logic              mul_valid,
    input  logic              alu_wb_en,
    input  logic [4:0]        alu_wb_rd,
    input  logic [XLEN-1:0]   alu_wb_data,
    output logic              rf_write_en,
    output logic [4:0]        rf_write_reg,
    output logic [XLEN-1:0]   rf_write_data,
    output logic              busy,
    output logic              err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state, state_d;

    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [2*XLEN-1:0] result_q;
    logic [CW-1:0]     cnt_q;

    logic              sign_rs1, sign_rs2;
    logic [XLEN-1:0]   mag_rs1, mag_rs2;
    logic              zero_op;
    logic              accept, bypass, capture, timeout_hit;
    logic [XLEN-1:0]   wb_word;

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (issue_rs1_data == '0) || (issue_rs2_data == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Operand signedness and magnitudes. The most negative value maps to itself.
    always_comb begin
        sign_rs1 = ((issue_funct3 == F3_MULH) || (issue_funct3 == F3_MULHSU))
                   && issue_rs1_data[XLEN-1];
        sign_rs2 = (issue_funct3 == F3_MULH) && issue_rs2_data[XLEN-1];
        mag_rs1  = sign_rs1 ? (~issue_rs1_data + 1'b1) : issue_rs1_data;
        mag_rs2  = sign_rs2 ? (~issue_rs2_data + 1'b1) : issue_rs2_data;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic and the handshake strobes.
    always_comb begin
        state_d     = state;
        mul_ld      = 1'b0;
        accept      = 1'b0;
        bypass      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (issue_valid) begin
                    accept = 1'b1;
                    if (zero_op) begin
                        bypass  = 1'b1;
                        state_d = WB;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                mul_ld  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_valid) begin
                    capture = 1'b1;
                    state_d = WB;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            WB: begin
                if (rd_q == 5'd0 || !alu_wb_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the low word for MUL and the high word for the MULH variants.
    assign wb_word = (funct3_q == F3_MUL) ? result_q[XLEN-1:0] : result_q[2*XLEN-1:XLEN];

    // Regfile write port. ALU writes pass through. The multiply write uses the port only when the ALU is idle.
    always_comb begin
        rf_write_en   = alu_wb_en;
        rf_write_reg  = alu_wb_rd;
        rf_write_data = alu_wb_data;
        if (!alu_wb_en && state == WB && rd_q != 5'd0) begin
            rf_write_en   = 1'b1;
            rf_write_reg  = rd_q;
            rf_write_data = wb_word;
        end
    end

    // Operand latch, result capture, timeout counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q <= issue_funct3;
                rd_q     <= issue_rd;
                neg_q    <= sign_rs1 ^ sign_rs2;
                mul_a    <= mag_rs2;
                mul_b    <= mag_rs1;
            end
            if (bypass) result_q <= '0;
            if (capture) result_q <= neg_q ? (~mul_out + 1'b1) : mul_out;
            if (state == LOAD)
                cnt_q <= '0;
            else if (state == WAIT && !mul_valid && !timeout_hit)
                cnt_q <= cnt_q + CW'(1);
            if (timeout_hit) err <= 1'b1;
        end
    end

    assign issue_ready = (state == IDLE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl. The expected values are hand-computed products and write words.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_funct3;
    logic [4:0]  issue_rd;
    logic [31:0] issue_rs1_data, issue_rs2_data;
    logic        mul_ld;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_out;
    logic        mul_valid;
    logic        alu_wb_en;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        rf_write_en;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        busy, err;

    int total = 0;
    int bad   = 0;

    mul_seq_ctrl #(.XLEN(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_funct3(issue_funct3), .issue_rd(issue_rd),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .mul_ld(mul_ld), .mul_a(mul_a), .mul_b(mul_b),
        .mul_out(mul_out), .mul_valid(mul_valid),
        .alu_wb_en(alu_wb_en), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply, answer after lat cycles, and hold the ALU on the port for alu_n cycles during WB.
    task automatic do_mul(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] exp_a, input logic [31:0] exp_b,
                          input logic [63:0] prod, input logic [31:0] exp_wr,
                          input int lat, input int alu_n);
        int extra_ld;
        int early_wr;
        chk({tag, "_ready_idle"}, 64'(issue_ready), 64'd1);
        issue_valid = 1'b1; issue_funct3 = f3; issue_rd = rd;
        issue_rs1_data = rs1; issue_rs2_data = rs2;
        tick();
        issue_valid = 1'b0;
        chk({tag, "_ld_c1"}, 64'(mul_ld), 64'd1);
        chk({tag, "_busy_c1"}, 64'(busy), 64'd1);
        chk({tag, "_mul_a"}, 64'(mul_a), 64'(exp_a));
        chk({tag, "_mul_b"}, 64'(mul_b), 64'(exp_b));
        extra_ld = 0;
        early_wr = 0;
        for (int i = 0; i < lat; i++) begin
            tick();
            if (mul_ld) extra_ld++;
            if (rf_write_en) early_wr++;
        end
        chk({tag, "_ld_once"}, 64'(extra_ld), 64'd0);
        chk({tag, "_no_early_wr"}, 64'(early_wr), 64'd0);
        mul_valid = 1'b1; mul_out = prod;
        tick();
        mul_valid = 1'b0; mul_out = '0;
        for (int i = 0; i < alu_n; i++) begin
            alu_wb_en = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h11;
            #1;
            chk({tag, "_alu_en"}, 64'(rf_write_en), 64'd1);
            chk({tag, "_alu_reg"}, 64'(rf_write_reg), 64'd3);
            chk({tag, "_alu_data"}, 64'(rf_write_data), 64'h11);
            chk({tag, "_alu_ready"}, 64'(issue_ready), 64'd0);
            tick();
        end
        alu_wb_en = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
        #1;
        chk({tag, "_wr_en"}, 64'(rf_write_en), 64'(rd != 5'd0));
        if (rd != 5'd0) begin
            chk({tag, "_wr_reg"}, 64'(rf_write_reg), 64'(rd));
            chk({tag, "_wr_data"}, 64'(rf_write_data), 64'(exp_wr));
        end
        tick();
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_no_wr_after"}, 64'(rf_write_en), 64'd0);
    endtask

    initial begin
        int w;
        rst = 1'b1; issue_valid = 1'b0; issue_funct3 = '0; issue_rd = '0;
        issue_rs1_data = '0; issue_rs2_data = '0; mul_out = '0; mul_valid = 1'b0;
        alu_wb_en = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
        tick();
        tick();
        chk("rst_ready", 64'(issue_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ld", 64'(mul_ld), 64'd0);
        chk("rst_a", 64'(mul_a), 64'd0);
        chk("rst_b", 64'(mul_b), 64'd0);
        alu_wb_en = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'h55;
        #1;
        chk("rst_alu_en", 64'(rf_write_en), 64'd1);
        chk("rst_alu_data", 64'(rf_write_data), 64'h55);
        alu_wb_en = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
        rst = 1'b0;
        tick();

        do_mul("mul7x6", 3'b000, 5'd5, 32'd7, 32'd6, 32'd6, 32'd7, 64'd42, 32'd42, 33, 0);
        do_mul("mulh_m1x2", 3'b001, 5'd6, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd1,
               64'd2, 32'hFFFFFFFF, 4, 0);
        do_mul("mulhu_m1x2", 3'b011, 5'd6, 32'hFFFFFFFF, 32'd2, 32'd2, 32'hFFFFFFFF,
               64'h1_FFFFFFFE, 32'h00000001, 4, 0);
        do_mul("mulhsu_m1x2", 3'b010, 5'd6, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd1,
               64'd2, 32'hFFFFFFFF, 4, 0);
        do_mul("mul_m1x2", 3'b000, 5'd6, 32'hFFFFFFFF, 32'd2, 32'd2, 32'hFFFFFFFF,
               64'h1_FFFFFFFE, 32'hFFFFFFFE, 4, 0);
        do_mul("mulh_min", 3'b001, 5'd8, 32'h80000000, 32'h80000000, 32'h80000000,
               32'h80000000, 64'h40000000_00000000, 32'h40000000, 5, 0);
        do_mul("collide", 3'b000, 5'd10, 32'd3, 32'd5, 32'd5, 32'd3, 64'd15, 32'd15, 2, 3);
        do_mul("rd0", 3'b000, 5'd0, 32'd3, 32'd5, 32'd5, 32'd3, 64'd15, 32'd0, 2, 0);

        // Timeout: mul_valid never arrives.
        issue_valid = 1'b1; issue_funct3 = 3'b000; issue_rd = 5'd7;
        issue_rs1_data = 32'd9; issue_rs2_data = 32'd9;
        tick();
        issue_valid = 1'b0;
        w = 0;
        for (int c = 2; c <= 65; c++) begin
            tick();
            if (rf_write_en) w++;
        end
        chk("tmo_err_c65", 64'(err), 64'd0);
        chk("tmo_busy_c65", 64'(busy), 64'd1);
        tick();
        chk("tmo_err", 64'(err), 64'd1);
        chk("tmo_ready", 64'(issue_ready), 64'd1);
        chk("tmo_no_wr", 64'(w + int'(rf_write_en)), 64'd0);
        tick();
        chk("tmo_err_sticky", 64'(err), 64'd1);

        // Reset in WAIT drops the pending result and clears err.
        issue_valid = 1'b1; issue_funct3 = 3'b000; issue_rd = 5'd12;
        issue_rs1_data = 32'd6; issue_rs2_data = 32'd7;
        tick();
        issue_valid = 1'b0;
        tick();
        tick();
        chk("wait_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_ready", 64'(issue_ready), 64'd1);
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_err", 64'(err), 64'd0);
        chk("rstw_ld", 64'(mul_ld), 64'd0);
        chk("rstw_a", 64'(mul_a), 64'd0);
        chk("rstw_b", 64'(mul_b), 64'd0);
        mul_valid = 1'b1; mul_out = 64'd42;
        #1;
        chk("late_valid_wr0", 64'(rf_write_en), 64'd0);
        tick();
        mul_valid = 1'b0; mul_out = '0;
        chk("late_valid_wr1", 64'(rf_write_en), 64'd0);
        chk("late_valid_busy", 64'(busy), 64'd0);

`ifdef MUL_ZERO_BYPASS_EN
        issue_valid = 1'b1; issue_funct3 = 3'b000; issue_rd = 5'd4;
        issue_rs1_data = 32'd0; issue_rs2_data = 32'd5;
        tick();
        issue_valid = 1'b0;
        chk("byp_no_ld", 64'(mul_ld), 64'd0);
        chk("byp_wr_en", 64'(rf_write_en), 64'd1);
        chk("byp_wr_reg", 64'(rf_write_reg), 64'd4);
        chk("byp_wr_data", 64'(rf_write_data), 64'd0);
        tick();
        chk("byp_busy_after", 64'(busy), 64'd0);
`else
        do_mul("zero_x5", 3'b000, 5'd4, 32'd0, 32'd5, 32'd5, 32'd0, 64'd0, 32'd0, 3, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
